traffic_conflict_monitor: RTL and testbench

- Independent supervisor on the receiving end of the traffic controller's light bus (LG/SG/RG/R, one bit per approach, 4 approaches).
- Decodes the driven pattern into a phase, and checks for conflicting greens, phase sequence, and dwell time.
- Latches a coded fault and commands all-red flash.
- Sits between the controller outputs and the lamp drivers.

---
 rtl/traffic_pkg.sv | 18 +
 rtl/traffic_conflict_monitor_if.sv | 16 +
 rtl/tl_pattern_decode.sv | 31 +++
 rtl/traffic_conflict_monitor.sv | 98 +++++++++
 tb/tb_traffic_conflict_monitor.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/traffic_pkg.sv
// traffic_pkg: shared state encoding, fault codes and phase patterns for the light-bus monitor
package traffic_pkg;
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_MONITOR = 2'd1;
  localparam logic [1:0] ST_FAULT   = 2'd2;
  localparam logic [2:0] FC_NONE          = 3'd0;
  localparam logic [2:0] FC_MULTI_GREEN   = 3'd1;
  localparam logic [2:0] FC_GREEN_RED     = 3'd2;
  localparam logic [2:0] FC_DARK_APPROACH = 3'd3;
  localparam logic [2:0] FC_SEQUENCE      = 3'd4;
  localparam logic [2:0] FC_SHORT_DWELL   = 3'd5;
  localparam logic [2:0] FC_STUCK         = 3'd6;
  localparam logic [2:0] FC_ALL_DARK      = 3'd7;
  localparam logic [3:0] PH_OH [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
  function automatic logic [1:0] next_phase(input logic [1:0] p);
    return p + 2'd1;
  endfunction
endpackage

// File: rtl/traffic_conflict_monitor_if.sv
// traffic_conflict_monitor_if: light bus from the controller plus the monitor's status outputs
interface traffic_conflict_monitor_if;
  logic       tick;
  logic       clr_fault;
  logic [3:0] LG;
  logic [3:0] SG;
  logic [3:0] RG;
  logic [3:0] R;
  logic [1:0] phase_id;
  logic       phase_valid;
  logic       fault;
  logic [2:0] fault_code;
  logic       flash_all;
  modport master (output tick, clr_fault, LG, SG, RG, R, input phase_id, phase_valid, fault, fault_code, flash_all);
  modport slave (input tick, clr_fault, LG, SG, RG, R, output phase_id, phase_valid, fault, fault_code, flash_all);
endinterface

// File: rtl/tl_pattern_decode.sv
// tl_pattern_decode: classifies a lamp pattern as a legal phase, dark, or an error cause
module tl_pattern_decode
  import traffic_pkg::*;
(
  input  logic [3:0] lg,
  input  logic [3:0] sg,
  input  logic [3:0] rg,
  input  logic [3:0] r,
  output logic       legal,
  output logic [1:0] phase,
  output logic       dark,
  output logic [2:0] err_code
);
  logic [3:0] g;
  assign g = lg | sg | rg;
  assign dark = ~|{lg, sg, rg, r};
  always_comb begin
    legal = 1'b0;
    phase = 2'd0;
    for (int k = 0; k < 4; k++) begin
      if (lg == PH_OH[k] && sg == PH_OH[k] && (rg == 4'b0 || rg == PH_OH[k]) && r == ~PH_OH[k]) begin
        legal = 1'b1;
        phase = 2'(k);
      end
    end
  end
  assign err_code = (legal || dark) ? FC_NONE :
                    |(g & (g - 4'd1)) ? FC_MULTI_GREEN :
                    |(g & r) ? FC_GREEN_RED :
                    ~&(g | r) ? FC_DARK_APPROACH : FC_MULTI_GREEN;
endmodule

// File: rtl/traffic_conflict_monitor.sv
// traffic_conflict_monitor: supervises the light bus for conflicts, sequence and dwell, latching faults into all-red flash
module traffic_conflict_monitor
  import traffic_pkg::*;
#(
  parameter int MIN_DWELL = 1,
  parameter int MAX_DWELL = 2,
  parameter int DEBOUNCE  = 2,
  parameter int CNT_W     = 8
) (
  input logic clk,
  input logic rst,
  traffic_conflict_monitor_if.slave bus
);
  localparam logic [CNT_W-1:0] MIN_C  = CNT_W'(MIN_DWELL);
  localparam logic [CNT_W-1:0] MAX_M1 = CNT_W'(MAX_DWELL - 1);
  localparam logic [CNT_W-1:0] DEB_M1 = CNT_W'(DEBOUNCE - 1);
  logic             legal, dark, go_fault;
  logic [1:0]       phase;
  logic [2:0]       err_code, cause;
  logic [1:0]       state_q, state_d, phase_q, phase_d;
  logic [CNT_W-1:0] dwell_q, dwell_d, deb_q, deb_d;
  logic [2:0]       code_q, code_d;
  logic             flash_q, flash_d;
  tl_pattern_decode u_dec (
    .lg(bus.LG), .sg(bus.SG), .rg(bus.RG), .r(bus.R),
    .legal(legal), .phase(phase), .dark(dark), .err_code(err_code)
  );
  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    dwell_d  = dwell_q;
    deb_d    = deb_q;
    code_d   = code_q;
    flash_d  = flash_q;
    go_fault = 1'b0;
    cause    = (state_q == ST_MONITOR && dark) ? FC_ALL_DARK : err_code;
    if (state_q == ST_FAULT) begin
      if (bus.clr_fault) begin
        state_d = ST_IDLE;
        phase_d = '0;
        dwell_d = '0;
        deb_d   = '0;
        code_d  = FC_NONE;
        flash_d = 1'b0;
      end else begin
        flash_d = flash_q ^ bus.tick;
      end
    end else if (cause != FC_NONE) begin
      go_fault = deb_q >= DEB_M1;
      deb_d    = (deb_q == '1) ? deb_q : deb_q + CNT_W'(1);
    end else begin
      deb_d = '0;
      if (state_q == ST_IDLE) begin
        state_d = legal ? ST_MONITOR : ST_IDLE;
        phase_d = legal ? phase : phase_q;
        dwell_d = '0;
      end else if (phase != phase_q) begin
        cause    = (phase != next_phase(phase_q)) ? FC_SEQUENCE : FC_SHORT_DWELL;
        go_fault = phase != next_phase(phase_q) || dwell_q < MIN_C;
        phase_d  = go_fault ? phase_q : phase;
        dwell_d  = '0;
      end else if (bus.tick) begin
        cause    = FC_STUCK;
        go_fault = dwell_q >= MAX_M1;
        dwell_d  = (dwell_q == '1) ? dwell_q : dwell_q + CNT_W'(1);
      end
    end
    if (go_fault) begin
      state_d = ST_FAULT;
      code_d  = cause;
      flash_d = 1'b1;
      deb_d   = '0;
      dwell_d = '0;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      phase_q <= '0;
      dwell_q <= '0;
      deb_q   <= '0;
      code_q  <= FC_NONE;
      flash_q <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      dwell_q <= dwell_d;
      deb_q   <= deb_d;
      code_q  <= code_d;
      flash_q <= flash_d;
    end
  end
  assign bus.phase_id    = phase_q;
  assign bus.phase_valid = state_q == ST_MONITOR;
  assign bus.fault       = state_q == ST_FAULT;
  assign bus.fault_code  = code_q;
  assign bus.flash_all   = flash_q;
endmodule

// File: tb/tb_traffic_conflict_monitor.sv
// tb_traffic_conflict_monitor: directed and randomized checks of the light-bus monitor against a rule-level model
module tb_traffic_conflict_monitor;
  localparam int MIN = 1;
  localparam int MAX = 2;
  localparam int DEB = 2;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int fails = 0;
  int m_mode, m_phase, m_ticks, m_run, m_code;
  bit m_flash;
  traffic_conflict_monitor_if bus ();
  traffic_conflict_monitor #(.MIN_DWELL(MIN), .MAX_DWELL(MAX), .DEBOUNCE(DEB), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic model_reset();
    m_mode = 0; m_phase = 0; m_ticks = 0; m_run = 0; m_code = 0; m_flash = 0;
  endtask
  function automatic void classify(input logic [3:0] lg, sg, rg, r, output bit legal, output int k,
                                   output bit dark, output int code);
    int ng, g;
    bit overlap, empty;
    ng = 0; overlap = 0; empty = 0; legal = 0; k = 0;
    for (int i = 0; i < 4; i++) begin
      g = int'(lg[i] | sg[i] | rg[i]);
      ng += g;
      if (g != 0 && r[i]) overlap = 1;
      if (g == 0 && !r[i]) empty = 1;
      if (lg == 4'(1 << i) && sg == lg && (rg == 4'b0 || rg == lg) && r == ~lg) begin
        legal = 1; k = i;
      end
    end
    dark = {lg, sg, rg, r} == 16'h0;
    code = (legal || dark) ? 0 : ng > 1 ? 1 : overlap ? 2 : empty ? 3 : 1;
  endfunction
  task automatic enter_fault(input int c);
    m_mode = 2; m_code = c; m_flash = 1; m_run = 0; m_ticks = 0;
  endtask
  task automatic model_step(input logic [3:0] lg, sg, rg, r, input logic tk, input logic clr);
    bit legal, dark;
    int k, code;
    classify(lg, sg, rg, r, legal, k, dark, code);
    if (m_mode == 2) begin
      if (clr) model_reset();
      else if (tk) m_flash = ~m_flash;
    end else begin
      if (m_mode == 1 && dark) code = 7;
      if (code != 0) begin
        m_run++;
        if (m_run >= DEB) enter_fault(code);
      end else begin
        m_run = 0;
        if (m_mode == 0) begin
          if (legal) begin m_mode = 1; m_phase = k; m_ticks = 0; end
        end else if (k != m_phase) begin
          if (k != (m_phase + 1) % 4) enter_fault(4);
          else if (m_ticks < MIN) enter_fault(5);
          else begin m_phase = k; m_ticks = 0; end
        end else if (tk) begin
          m_ticks++;
          if (m_ticks >= MAX) enter_fault(6);
        end
      end
    end
  endtask
  task automatic cycle(input logic [3:0] lg, sg, rg, r, input logic tk, input logic clr);
    bus.LG = lg; bus.SG = sg; bus.RG = rg; bus.R = r; bus.tick = tk; bus.clr_fault = clr;
    @(posedge clk);
    model_step(lg, sg, rg, r, tk, clr);
    #1;
  endtask
  task automatic ph(input int k, input logic tk);
    logic [3:0] oh;
    oh = 4'(1 << k);
    cycle(oh, oh, ($urandom_range(0, 1) != 0) ? oh : 4'b0, ~oh, tk, 1'b0);
  endtask
  task automatic clr_cycle();
    cycle(4'b0, 4'b0, 4'b0, 4'b0, 1'b0, 1'b1);
  endtask
  function automatic logic [7:0] dut_vec();
    return {bus.phase_valid, bus.fault, bus.fault_code, bus.flash_all, bus.phase_id};
  endfunction
  function automatic logic [7:0] mdl_vec();
    return {m_mode == 1, m_mode == 2, 3'(m_code), m_flash, 2'(m_phase)};
  endfunction
  task automatic test_reset();
    bus.LG = 0; bus.SG = 0; bus.RG = 0; bus.R = 0; bus.tick = 0; bus.clr_fault = 0;
    model_reset();
    #13;
    checks++;
    if (dut_vec() !== 8'h00) begin $display("FAIL reset: got %b want 00000000", dut_vec()); fails++; end
    @(negedge clk);
    rst = 1'b1;
  endtask
  task automatic test_nominal();
    cycle(4'b0, 4'b0, 4'b0, 4'b0, 1'b0, 1'b0);
    checks++;
    if (dut_vec() !== 8'h00) begin $display("FAIL idle_dark: got %b want 00000000", dut_vec()); fails++; end
    ph(0, 1'b0);
    checks++;
    if (bus.phase_valid !== 1'b1 || bus.phase_id !== 2'd0) begin
      $display("FAIL enter_ph0: got valid=%b id=%0d want valid=1 id=0", bus.phase_valid, bus.phase_id); fails++;
    end
    for (int n = 1; n <= 4; n++) begin
      ph((n - 1) % 4, 1'b1);
      ph(n % 4, 1'b0);
      checks++;
      if (bus.phase_id !== 2'(n % 4) || bus.fault !== 1'b0 || dut_vec() !== mdl_vec()) begin
        $display("FAIL advance_%0d: got %b want %b", n, dut_vec(), mdl_vec()); fails++;
      end
    end
  endtask
  task automatic test_conflict();
    cycle(4'b0011, 4'b0011, 4'b0, 4'b1100, 1'b0, 1'b0);
    ph(0, 1'b0);
    checks++;
    if (bus.fault !== 1'b0 || bus.phase_valid !== 1'b1) begin
      $display("FAIL conflict_glitch: got fault=%b valid=%b want fault=0 valid=1", bus.fault, bus.phase_valid); fails++;
    end
    cycle(4'b0011, 4'b0011, 4'b0, 4'b1100, 1'b0, 1'b0);
    checks++;
    if (bus.fault !== 1'b0) begin $display("FAIL conflict_early: got fault=%b want 0", bus.fault); fails++; end
    cycle(4'b0011, 4'b0011, 4'b0, 4'b1100, 1'b0, 1'b0);
    checks++;
    if (bus.fault !== 1'b1 || bus.fault_code !== 3'd1 || bus.flash_all !== 1'b1 || bus.phase_valid !== 1'b0) begin
      $display("FAIL conflict_fault: got %b want fault=1 code=1 flash=1 valid=0", dut_vec()); fails++;
    end
    clr_cycle();
    checks++;
    if (dut_vec() !== 8'h00) begin $display("FAIL conflict_clr: got %b want 00000000", dut_vec()); fails++; end
  endtask
  task automatic test_green_red();
    ph(1, 1'b0);
    cycle(4'b0010, 4'b0010, 4'b0, 4'b1111, 1'b0, 1'b0);
    checks++;
    if (bus.fault !== 1'b0 || bus.phase_id !== 2'd1) begin
      $display("FAIL green_red_early: got %b want fault=0 id=1", dut_vec()); fails++;
    end
    cycle(4'b0010, 4'b0010, 4'b0, 4'b1111, 1'b0, 1'b0);
    checks++;
    if (bus.fault_code !== 3'd2 || bus.fault !== 1'b1) begin
      $display("FAIL green_red: got code=%0d fault=%b want code=2 fault=1", bus.fault_code, bus.fault); fails++;
    end
    clr_cycle();
  endtask
  task automatic test_sequence();
    ph(0, 1'b0);
    ph(0, 1'b1);
    ph(2, 1'b0);
    checks++;
    if (bus.fault !== 1'b1 || bus.fault_code !== 3'd4) begin
      $display("FAIL sequence_skip: got fault=%b code=%0d want fault=1 code=4", bus.fault, bus.fault_code); fails++;
    end
    clr_cycle();
    ph(0, 1'b0);
    ph(1, 1'b0);
    checks++;
    if (bus.fault !== 1'b1 || bus.fault_code !== 3'd5) begin
      $display("FAIL short_dwell: got fault=%b code=%0d want fault=1 code=5", bus.fault, bus.fault_code); fails++;
    end
    clr_cycle();
    ph(3, 1'b0);
    cycle(4'b0, 4'b0, 4'b0, 4'b0, 1'b0, 1'b0);
    cycle(4'b0, 4'b0, 4'b0, 4'b0, 1'b0, 1'b0);
    checks++;
    if (bus.fault !== 1'b1 || bus.fault_code !== 3'd7) begin
      $display("FAIL all_dark: got fault=%b code=%0d want fault=1 code=7", bus.fault, bus.fault_code); fails++;
    end
    clr_cycle();
  endtask
  task automatic test_stuck_recovery();
    logic [2:0] want;
    ph(2, 1'b0);
    ph(2, 1'b1);
    checks++;
    if (bus.fault !== 1'b0) begin $display("FAIL stuck_early: got fault=%b want 0", bus.fault); fails++; end
    ph(2, 1'b1);
    checks++;
    if (bus.fault !== 1'b1 || bus.fault_code !== 3'd6 || bus.flash_all !== 1'b1) begin
      $display("FAIL stuck: got %b want fault=1 code=6 flash=1", dut_vec()); fails++;
    end
    want = 3'b010;
    for (int n = 0; n < 3; n++) begin
      cycle(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 1'b1, 1'b0);
      checks++;
      if (bus.flash_all !== want[n] || bus.fault_code !== 3'd6) begin
        $display("FAIL flash_%0d: got flash=%b code=%0d want flash=%b code=6", n, bus.flash_all, bus.fault_code, want[n]); fails++;
      end
    end
    clr_cycle();
    checks++;
    if (dut_vec() !== 8'h00) begin $display("FAIL recovery_clr: got %b want 00000000", dut_vec()); fails++; end
  endtask
  task automatic test_random();
    int rr, k;
    logic tk, clr;
    for (int n = 0; n < 3000; n++) begin
      rr = $urandom_range(0, 99);
      tk = $urandom_range(0, 2) == 0;
      clr = $urandom_range(0, 7) == 0;
      k = $urandom_range(0, 9);
      k = (k < 5) ? (m_phase + 1) % 4 : (k < 9) ? m_phase : $urandom_range(0, 3);
      if (rr < 70) ph(k, tk);
      else if (rr < 78) cycle(4'b0, 4'b0, 4'b0, 4'b0, tk, clr);
      else if (rr < 90) cycle(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), tk, clr);
      else cycle(4'(1 << k) | 4'(1 << $urandom_range(0, 3)), 4'(1 << k), 4'b0, ~4'(1 << k), tk, clr);
      if (clr && m_mode == 0) ph(k, 1'b0);
      checks++;
      if (dut_vec() !== mdl_vec()) begin
        $display("FAIL random_%0d: got %b want %b", n, dut_vec(), mdl_vec()); fails++;
      end
    end
  endtask
  task automatic test_async_reset();
    clr_cycle();
    ph(1, 1'b0);
    rst = 1'b0;
    #1;
    checks++;
    if (dut_vec() !== 8'h00) begin $display("FAIL async_reset: got %b want 00000000", dut_vec()); fails++; end
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    ph(0, 1'b0);
    checks++;
    if (dut_vec() !== mdl_vec()) begin $display("FAIL after_reset: got %b want %b", dut_vec(), mdl_vec()); fails++; end
  endtask
  initial begin
    test_reset();
    test_nominal();
    test_conflict();
    test_green_red();
    test_sequence();
    test_stuck_recovery();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
